div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 153 +++++++++++++++
 tb/tb_div_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared repeated-subtraction
// divider. Grants one request at a time, latches its operands, starts the
// divider, waits (with a watchdog) for completion and returns the result to
// the granted requester. Divide-by-zero and watchdog expiry both complete
// with err=1 and all-ones quotient/remainder.
module div_arbiter #(
  parameter int W   = 8,
  parameter int TMO = 300
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] dvd0,
  input  logic [W-1:0] dvs0,
  input  logic [W-1:0] dvd1,
  input  logic [W-1:0] dvs1,
  output logic [1:0]   gnt,
  output logic [1:0]   rsp_vld,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         err,
  output logic         busy,
  output logic         div_start,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic         div_done,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r
);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic           lp_q, lp_d;        // requester served last
  logic           id_q, id_d;        // requester owning the operation in flight
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cnt_nx;
  logic [W-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
  logic [W-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic [1:0]     rsp_vld_q, rsp_vld_d;
  logic           err_q, err_d;
  logic           div_start_q, div_start_d;
  logic           sel;
  logic [W-1:0]   sel_dvd, sel_dvs;

  // Next-state, grant selection and registered-output next values
  always_comb begin
    state_d     = state_q;
    lp_d        = lp_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    rsp_vld_d   = '0;
    err_d       = 1'b0;
    div_start_d = 1'b0;
    gnt         = '0;
    sel         = (req0 && req1) ? ~lp_q : req1;
    sel_dvd     = sel ? dvd1 : dvd0;
    sel_dvs     = sel ? dvs1 : dvs0;
    cnt_nx      = (cnt_q == CW'(TMO)) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt     = sel ? 2'b10 : 2'b01;
          div_a_d = sel_dvd;
          div_b_d = sel_dvs;
          lp_d    = sel;
          id_d    = sel;
          if (sel_dvs == '0) begin
            // Divide-by-zero completes without ever touching the divider
            state_d   = S_RESP;
            rsp_vld_d = sel ? 2'b10 : 2'b01;
            err_d     = 1'b1;
            quot_d    = '1;
            rem_d     = '1;
          end else begin
            state_d     = S_ISSUE;
            div_start_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_nx;
        if (div_done) begin
          state_d   = S_RESP;
          rsp_vld_d = id_q ? 2'b10 : 2'b01;
          quot_d    = div_q;
          rem_d     = div_r;
        end else if (cnt_nx == CW'(TMO)) begin
          state_d   = S_RESP;
          rsp_vld_d = id_q ? 2'b10 : 2'b01;
          err_d     = 1'b1;
          quot_d    = '1;
          rem_d     = '1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lp_q        <= 1'b1;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      rsp_vld_q   <= '0;
      err_q       <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lp_q        <= lp_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      rsp_vld_q   <= rsp_vld_d;
      err_q       <= err_d;
      div_start_q <= div_start_d;
    end
  end

  assign rsp_vld   = rsp_vld_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);
  assign div_start = div_start_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level reference.
module tb_div_arbiter;
  localparam int W   = 8;
  localparam int TMO = 300;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] dvd0 = '0, dvs0 = '0, dvd1 = '0, dvs1 = '0;
  logic [1:0]   gnt, rsp_vld;
  logic [W-1:0] quot, rem, div_a, div_b;
  logic         err, busy, div_start;
  logic         div_done = 1'b0;
  logic [W-1:0] div_q = '0, div_r = '0;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  bit hang_m = 1'b0;
  int last_m = 1;

  // divider model state
  int           left_m = 0;
  bit           run_m = 1'b0;
  logic [W-1:0] mq = '0, mr = '0;

  always #5 clk = ~clk;

  div_arbiter #(.W(W), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .dvd0(dvd0), .dvs0(dvs0), .dvd1(dvd1), .dvs1(dvs1),
    .gnt(gnt), .rsp_vld(rsp_vld), .quot(quot), .rem(rem), .err(err),
    .busy(busy), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  // Repeated-subtraction divider: one iteration per quotient unit; not reset
  always @(posedge clk) begin
    div_done <= 1'b0;
    if (div_start) begin
      mq <= div_a / div_b;
      mr <= div_a % div_b;
      if (hang_m) begin
        run_m <= 1'b0;
      end else if (div_a / div_b == 0) begin
        div_done <= 1'b1;
        div_q    <= div_a / div_b;
        div_r    <= div_a % div_b;
        run_m    <= 1'b0;
      end else begin
        left_m <= int'(div_a / div_b);
        run_m  <= 1'b1;
      end
    end else if (run_m) begin
      if (left_m == 1) begin
        div_done <= 1'b1;
        div_q    <= mq;
        div_r    <= mr;
        run_m    <= 1'b0;
      end
      left_m <= left_m - 1;
    end
  end

  // count divider start pulses
  always @(posedge clk) if (div_start === 1'b1) starts <= starts + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {gnt, rsp_vld, err, busy, div_start, div_a, div_b, quot, rem}, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_m = 1;
  endtask

  // One request/response transaction; reference computed from the rules
  task automatic transact(input bit r0, input bit r1, input bit hold0, input bit hold1,
                          input bit mid1);
    int w, n, e, exp_e, s0;
    bit div0, to, got;
    logic [W-1:0] a, b, eq, er;
    @(negedge clk);
    req0 = r0;
    req1 = r1;
    #1;
    w = (r0 && r1) ? ((last_m == 0) ? 1 : 0) : (r1 ? 1 : 0);
    check("gnt", 64'(gnt), (w == 1) ? 64'd2 : 64'd1);
    a = (w == 1) ? dvd1 : dvd0;
    b = (w == 1) ? dvs1 : dvs0;
    last_m = w;
    s0 = starts;
    div0 = (b == 0);
    to = !div0 && hang_m;
    eq = (div0 || to) ? 8'hFF : a / b;
    er = (div0 || to) ? 8'hFF : a % b;
    n = to ? TMO : (int'(a / b) + 1);
    exp_e = div0 ? 1 : n + 2;
    @(posedge clk);
    #1;
    check("busy_after_gnt", 64'({busy, gnt}), 64'b100);
    if (!div0) check("div_operands", 64'({div_a, div_b}), 64'({a, b}));
    if (w == 0) begin
      if (!hold0) req0 = 1'b0;
      dvd0 = W'($urandom);
      dvs0 = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
    end else begin
      if (!hold1) req1 = 1'b0;
      dvd1 = W'($urandom);
      dvs1 = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
    end
    if (mid1) req1 = 1'b1;
    e = 1;
    got = 1'b0;
    while (e <= TMO + 20) begin
      if (rsp_vld != 2'b00) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      e++;
    end
    check("rsp_seen", 64'(got), 64'd1);
    check("latency", 64'(e), 64'(exp_e));
    check("rsp_vld", 64'(rsp_vld), (w == 1) ? 64'd2 : 64'd1);
    check("err", 64'(err), 64'(div0 || to));
    check("quot", 64'(quot), 64'(eq));
    check("rem", 64'(rem), 64'(er));
    check("div_starts", 64'(starts - s0), div0 ? 64'd0 : 64'd1);
    @(posedge clk);
    #1;
    check("idle_outputs", 64'({rsp_vld, err, busy}), 64'd0);
    check("result_hold", 64'({quot, rem}), 64'({eq, er}));
  endtask

  initial begin
    bit seen;
    #12;
    check("reset_initial", {gnt, rsp_vld, err, busy, div_start, div_a, div_b, quot, rem}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic 100/7
    dvd0 = 8'd100; dvs0 = 8'd7;
    transact(1, 0, 0, 0, 0);

    // tie after reset: requester 0 first, then requester 1, then tie again
    do_reset();
    dvd0 = 8'd200; dvs0 = 8'd10; dvd1 = 8'd9; dvs1 = 8'd4;
    transact(1, 1, 0, 0, 0);
    transact(0, 1, 0, 0, 0);
    dvd0 = 8'd17; dvs0 = 8'd5; dvd1 = 8'd33; dvs1 = 8'd6;
    transact(1, 1, 0, 0, 0);
    transact(0, 1, 0, 0, 0);

    // divide-by-zero on requester 1
    dvd1 = 8'd55; dvs1 = 8'd0;
    transact(0, 1, 0, 0, 0);

    // watchdog expiry, then recovery
    hang_m = 1'b1;
    dvd0 = 8'd50; dvs0 = 8'd5;
    transact(1, 0, 0, 0, 0);
    hang_m = 1'b0;
    dvd0 = 8'd77; dvs0 = 8'd8;
    transact(1, 0, 0, 0, 0);

    // reset in the middle of a 255/1 operation
    dvd0 = 8'd255; dvs0 = 8'd1;
    @(negedge clk);
    req0 = 1'b1;
    #1;
    check("gnt_before_abort", 64'(gnt), 64'd1);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {gnt, rsp_vld, err, busy, div_start, div_a, div_b, quot, rem}, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_m = 1;
    seen = 1'b0;
    repeat (280) begin
      @(posedge clk);
      #1;
      if (rsp_vld != 2'b00 || busy) seen = 1'b1;
    end
    check("no_rsp_after_abort", 64'(seen), 64'd0);
    dvd0 = 8'd10; dvs0 = 8'd3;
    transact(1, 0, 0, 0, 0);

    // req0 held continuously; req1 raised mid-stream
    dvd0 = 8'd40; dvs0 = 8'd9;
    transact(1, 0, 1, 0, 0);
    transact(1, 0, 1, 0, 1);
    transact(1, 1, 1, 0, 0);
    transact(1, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 16; i++) begin
      bit a0, a1;
      a0 = 1'($urandom);
      a1 = 1'($urandom);
      if (!a0 && !a1) a0 = 1'b1;
      hang_m = ($urandom_range(0, 7) == 0);
      transact(a0, a1, 0, 0, 0);
      req0 = 1'b0;
      req1 = 1'b0;
    end
    hang_m = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
